// File: rtl/fetch_hazard_scheduler.sv
// Fetch sequencer: streams a program out of a 1-cycle registered instruction memory
// and inserts NOP bubbles whenever a source register is still in flight.
module fetch_hazard_scheduler #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    HAZARD_DIST = 3,
  parameter int                    LAST_ADDR   = 7,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] issue_addr,
  output logic                  stall,
  output logic [15:0]           bubble_count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [5:0]            OP_ALU   = 6'b000100;
  localparam logic [5:0]            OP_LOAD  = 6'b000101;
  localparam logic [5:0]            OP_STORE = 6'b000110;
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   fetch_ptr, dec_addr;
  logic [DATA_WIDTH-1:0]   hold_reg, cand;
  logic [HAZARD_DIST-1:0]  sb_valid;
  logic [4:0]              sb_reg [HAZARD_DIST];
  logic [5:0]              op;
  logic [4:0]              rs, rt, rd, dest;
  logic                    reads_rs, reads_rt, writes;
  logic                    active, hazard, issue, last_issue;

  assign imem_addr = fetch_ptr;
  assign busy      = (state == RUN) || (state == STALL);

  // In STALL the held word is the candidate; memory output already shows the next word.
  always_comb begin
    cand       = (state == STALL) ? hold_reg : imem_data;
    op         = cand[31:26];
    rs         = cand[25:21];
    rt         = cand[20:16];
    rd         = cand[15:11];
    reads_rs   = (op == OP_ALU) || (op == OP_LOAD) || (op == OP_STORE);
    reads_rt   = (op == OP_ALU) || (op == OP_STORE);
    writes     = (op == OP_ALU) || (op == OP_LOAD);
    dest       = (op == OP_LOAD) ? rt : rd;
    active     = (state == RUN) || (state == STALL);
    hazard     = 1'b0;
    for (int i = 0; i < HAZARD_DIST; i++) begin
      if (sb_valid[i] && ((reads_rs && (rs == sb_reg[i])) || (reads_rt && (rt == sb_reg[i]))))
        hazard = 1'b1;
    end
    hazard     = hazard && active;
    issue      = active && !hazard;
    last_issue = issue && (dec_addr == LAST);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN, STALL: begin
        if (hazard)          state_next = STALL;
        else if (last_issue) state_next = DONE;
        else                 state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_ptr    <= '0;
      dec_addr     <= '0;
      hold_reg     <= NOP_WORD;
      sb_valid     <= '0;
      for (int i = 0; i < HAZARD_DIST; i++) sb_reg[i] <= '0;
      instr_out    <= NOP_WORD;
      instr_valid  <= 1'b0;
      issue_addr   <= '0;
      stall        <= 1'b0;
      bubble_count <= '0;
      done         <= 1'b0;
    end else if (!active) begin
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
      stall       <= 1'b0;
      done        <= (state == DONE);
      if (start) begin
        fetch_ptr    <= ADDR_WIDTH'(1);
        dec_addr     <= '0;
        sb_valid     <= '0;
        bubble_count <= '0;
        done         <= 1'b0;
      end
    end else begin
      // Entry 0 is the most recent issue slot; bubbles age the scoreboard too.
      for (int i = HAZARD_DIST - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_reg[i]   <= sb_reg[i-1];
      end
      sb_valid[0] <= issue && writes;
      sb_reg[0]   <= dest;
      if (hazard) begin
        instr_out   <= NOP_WORD;
        instr_valid <= 1'b0;
        stall       <= 1'b1;
        if (state == RUN) hold_reg <= imem_data;
        if (bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
      end else begin
        instr_out   <= cand;
        instr_valid <= 1'b1;
        stall       <= 1'b0;
        issue_addr  <= dec_addr;
        dec_addr    <= dec_addr + ADDR_WIDTH'(1);
        fetch_ptr   <= last_issue ? '0 : fetch_ptr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule
